store_drain: RTL and testbench

Drain stage directly downstream of the 16-entry store buffer. Takes the head entry the buffer presents, holds it in a one-deep register, and writes it into the data cache through a request/ready/done handshake. Its `cache_is_busy` output is the buffer's only pop control: the buffer shifts out entry 0 on every edge where `cache_is_busy` is low. The block also classifies uncached addresses and counts drained stores.

---
 rtl/store_drain_if.sv | 38 +++
 rtl/store_drain.sv | 119 +++++++++++
 tb/tb_store_drain.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_drain_if.sv
// Store-drain bus bundle: store-buffer head entry, pop control, data-cache
// write handshake and drain status. The DUT uses modport slave; the
// environment (store buffer plus cache) uses modport master.
interface store_drain_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 32;

  logic              sb_store_en;
  logic [ADDR_W-1:0] sb_store_addr;
  logic [DATA_W-1:0] sb_store_data;
  logic [STRB_W-1:0] sb_store_rwen;
  logic              cache_is_busy;
  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [DATA_W-1:0] dc_wr_data;
  logic [STRB_W-1:0] dc_wr_strb;
  logic              dc_wr_uncache;
  logic              dc_wr_ready;
  logic              dc_wr_done;
  logic              drain_idle;
  logic [CNT_W-1:0]  drained_cnt;

  modport slave (
    input  sb_store_en, sb_store_addr, sb_store_data, sb_store_rwen,
    input  dc_wr_ready, dc_wr_done,
    output cache_is_busy, dc_wr_req, dc_wr_addr, dc_wr_data, dc_wr_strb,
    output dc_wr_uncache, drain_idle, drained_cnt
  );

  modport master (
    output sb_store_en, sb_store_addr, sb_store_data, sb_store_rwen,
    output dc_wr_ready, dc_wr_done,
    input  cache_is_busy, dc_wr_req, dc_wr_addr, dc_wr_data, dc_wr_strb,
    input  dc_wr_uncache, drain_idle, drained_cnt
  );
endinterface

// File: rtl/store_drain.sv
// store_drain: one-deep drain stage between the store buffer and the data
// cache. Captures the buffer head, issues a cache write via req/ready/done,
// flags uncached addresses and counts completed stores.
// Optional feature macro: STORE_DRAIN_FASTRET_EN (capture the next entry on
// the done edge, giving a 3-cycle store-to-store period instead of 4).
module store_drain #(
  parameter logic [31:0] UNCACHE_BASE = 32'hA000_0000,
  parameter logic [31:0] UNCACHE_TOP  = 32'hBFFF_FFFF
) (
  input logic           clk,
  input logic           rst_,
  store_drain_if.slave  bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              uncache;
  } hold_t;

  state_t            state_q, state_d;
  hold_t             hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_c;
  logic              req_c;
  logic              entry_ok_c;
  hold_t             entry_c;

  // Head entry is worth draining only when valid with at least one byte enabled.
  assign entry_ok_c = bus.sb_store_en && (bus.sb_store_rwen != STRB_W'(0));

  // Hold-register image of the head entry; uncache uses the unaligned address.
  always_comb begin
    entry_c.addr    = {bus.sb_store_addr[ADDR_W-1:2], 2'b00};
    entry_c.data    = bus.sb_store_data;
    entry_c.strb    = bus.sb_store_rwen;
    entry_c.uncache = (bus.sb_store_addr >= UNCACHE_BASE) &&
                      (bus.sb_store_addr <= UNCACHE_TOP);
  end

  // State, hold register and drain counter.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, capture, count and handshake decode.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    busy_c  = 1'b0;
    req_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (entry_ok_c) begin
          hold_d  = entry_c;
          state_d = REQ;
        end
      end
      REQ: begin
        busy_c = 1'b1;
        req_c  = 1'b1;
        if (bus.dc_wr_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
`ifdef STORE_DRAIN_FASTRET_EN
        busy_c = !bus.dc_wr_done;
        if (bus.dc_wr_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
          if (entry_ok_c) begin
            hold_d  = entry_c;
            state_d = REQ;
          end
        end
`else
        busy_c = 1'b1;
        if (bus.dc_wr_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cache_is_busy = busy_c;
  assign bus.dc_wr_req     = req_c;
  assign bus.dc_wr_addr    = hold_q.addr;
  assign bus.dc_wr_data    = hold_q.data;
  assign bus.dc_wr_strb    = hold_q.strb;
  assign bus.dc_wr_uncache = hold_q.uncache;
  assign bus.drain_idle    = (state_q == IDLE);
  assign bus.drained_cnt   = cnt_q;
endmodule

// File: tb/tb_store_drain.sv
// Bench for store_drain: a store-buffer queue and a cache responder drive the
// DUT; a transaction-level model predicts pops, requests and the drain count.
module tb_store_drain;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rwen;
  } ent_t;

`ifdef STORE_DRAIN_FASTRET_EN
  localparam bit FASTRET = 1'b1;
  localparam int B2B_GAP = 3;
`else
  localparam bit FASTRET = 1'b0;
  localparam int B2B_GAP = 4;
`endif

  logic clk;
  logic rst_;
  store_drain_if bus();

  store_drain dut (.clk(clk), .rst_(rst_), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: buffer contents, store held by the drain stage, cache progress.
  ent_t        sbq[$];
  ent_t        cur;
  bit          pend;
  bit          acc;
  bit          req_seen;
  int          wait_left;
  logic [31:0] m_cnt;
  int          cyc;
  int          req_cyc[$];
  int          ready_pct;
  int          dmin;
  int          dmax;
  int          spur_pct;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_unc(input logic [31:0] a);
    return (a >= 32'hA000_0000) && (a <= 32'hBFFF_FFFF);
  endfunction

  task automatic chk_reset(input string pfx);
    chk({pfx, "_busy"}, 32'(bus.cache_is_busy), 32'd0);
    chk({pfx, "_idle"}, 32'(bus.drain_idle), 32'd1);
    chk({pfx, "_req"},  32'(bus.dc_wr_req), 32'd0);
    chk({pfx, "_addr"}, bus.dc_wr_addr, 32'd0);
    chk({pfx, "_data"}, bus.dc_wr_data, 32'd0);
    chk({pfx, "_strb"}, 32'(bus.dc_wr_strb), 32'd0);
    chk({pfx, "_unc"},  32'(bus.dc_wr_uncache), 32'd0);
    chk({pfx, "_cnt"},  bus.drained_cnt, 32'd0);
  endtask

  // One clock cycle: drive at negedge, check #1 later, advance model over the posedge.
  task automatic step();
    bit   exp_busy;
    bit   exp_req;
    bit   done;
    ent_t e;
    @(negedge clk);
    if (sbq.size() > 0) begin
      bus.sb_store_en   = 1'b1;
      bus.sb_store_addr = sbq[0].addr;
      bus.sb_store_data = sbq[0].data;
      bus.sb_store_rwen = sbq[0].rwen;
    end else begin
      bus.sb_store_en   = 1'b0;
      bus.sb_store_addr = $urandom;
      bus.sb_store_data = $urandom;
      bus.sb_store_rwen = 4'($urandom_range(1, 15));
    end
    bus.dc_wr_ready = ($urandom_range(0, 99) < ready_pct);
    if (pend && acc) done = (wait_left == 0);
    else             done = ($urandom_range(0, 99) < spur_pct);
    bus.dc_wr_done = done;
    #1;
    exp_busy = pend && !(FASTRET && acc && done);
    exp_req  = pend && !acc;
    chk("busy", 32'(bus.cache_is_busy), 32'(exp_busy));
    chk("idle", 32'(bus.drain_idle), 32'(!pend));
    chk("req",  32'(bus.dc_wr_req), 32'(exp_req));
    chk("cnt",  bus.drained_cnt, m_cnt);
    if (exp_req) begin
      chk("addr", bus.dc_wr_addr, cur.addr & 32'hFFFF_FFFC);
      chk("data", bus.dc_wr_data, cur.data);
      chk("strb", 32'(bus.dc_wr_strb), 32'(cur.rwen));
      chk("unc",  32'(bus.dc_wr_uncache), 32'(is_unc(cur.addr)));
      if (!req_seen) begin
        req_cyc.push_back(cyc);
        req_seen = 1'b1;
      end
    end
    if (pend && !acc) begin
      if (bus.dc_wr_ready) begin
        acc       = 1'b1;
        wait_left = $urandom_range(dmin, dmax);
      end
    end else if (pend && acc) begin
      if (done) begin
        m_cnt = m_cnt + 32'd1;
        pend  = 1'b0;
        acc   = 1'b0;
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
    if (!exp_busy && sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.rwen != 4'd0) begin
        cur      = e;
        pend     = 1'b1;
        acc      = 1'b0;
        req_seen = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((sbq.size() != 0 || pend) && n < max_cyc) begin
      step();
      n++;
    end
    if (sbq.size() != 0 || pend) chk("drain_timeout", 32'd1, 32'd0);
    step();
    step();
  endtask

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] r);
    ent_t e;
    e.addr = a;
    e.data = d;
    e.rwen = r;
    return e;
  endfunction

  function automatic ent_t rand_ent();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = $urandom;
      1:       a = 32'h9FFF_FFF8 + 32'($urandom_range(0, 15));
      2:       a = 32'hBFFF_FFF8 + 32'($urandom_range(0, 15));
      default: a = 32'hA000_0000 + 32'($urandom);
    endcase
    return mk(a, $urandom, 4'($urandom_range(0, 15)));
  endfunction

  initial begin
    logic [31:0] c0;
    ent_t        bnd[4];
    rst_ = 1'b0;
    bus.sb_store_en = 1'b0;
    bus.sb_store_addr = '0;
    bus.sb_store_data = '0;
    bus.sb_store_rwen = '0;
    bus.dc_wr_ready = 1'b0;
    bus.dc_wr_done = 1'b0;
    pend = 1'b0; acc = 1'b0; req_seen = 1'b0; wait_left = 0;
    m_cnt = '0; cyc = 0; cur = '0;
    ready_pct = 100; dmin = 1; dmax = 1; spur_pct = 0;
    #23;
    chk_reset("rst");
    @(negedge clk);
    rst_ = 1'b1;

    // Single store, done two cycles after acceptance.
    dmin = 2; dmax = 2;
    sbq.push_back(mk(32'h0000_1006, 32'h1234_5678, 4'b1100));
    drain(40);
    chk("single_cnt", bus.drained_cnt, 32'd1);
    chk("single_idle", 32'(bus.drain_idle), 32'd1);

    // Uncached range edges.
    dmin = 1; dmax = 1;
    bnd[0] = mk(32'h9FFF_FFFC, 32'h1111_1111, 4'hF);
    bnd[1] = mk(32'hA000_0000, 32'h2222_2222, 4'hF);
    bnd[2] = mk(32'hBFFF_FFFC, 32'h3333_3333, 4'hF);
    bnd[3] = mk(32'hC000_0000, 32'h4444_4444, 4'hF);
    for (int i = 0; i < 4; i++) sbq.push_back(bnd[i]);
    drain(60);

    // Ready held low for five cycles with another entry queued behind.
    ready_pct = 0;
    sbq.push_back(mk(32'h0000_2000, 32'hDEAD_BEEF, 4'b0011));
    sbq.push_back(mk(32'h0000_2004, 32'hCAFE_F00D, 4'b1111));
    step();
    for (int i = 0; i < 5; i++) step();
    chk("stall_q", 32'(sbq.size()), 32'd1);
    ready_pct = 100;
    drain(40);

    // Zero byte enables are popped and dropped.
    c0 = m_cnt;
    sbq.push_back(mk(32'h0000_3000, 32'h5555_5555, 4'b0000));
    sbq.push_back(mk(32'h0000_3008, 32'h6666_6666, 4'b0101));
    drain(40);
    chk("zero_cnt", bus.drained_cnt, c0 + 32'd1);

    // Back-to-back: request spacing with ready high, done one cycle later.
    c0 = m_cnt;
    req_cyc.delete();
    for (int i = 0; i < 3; i++) sbq.push_back(mk(32'h0000_4000 + 32'(i * 4), $urandom, 4'hF));
    drain(60);
    chk("b2b_nreq", 32'(req_cyc.size()), 32'd3);
    if (req_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'(B2B_GAP));
      chk("b2b_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'(B2B_GAP));
    end
    chk("b2b_cnt", bus.drained_cnt, c0 + 32'd3);

    // Randomized traffic.
    ready_pct = 60; dmin = 1; dmax = 3; spur_pct = 20;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0 && sbq.size() < 16) sbq.push_back(rand_ent());
      step();
    end
    drain(400);

    // Reset asserted mid-cycle while waiting for done.
    ready_pct = 100; dmin = 3; dmax = 3; spur_pct = 0;
    sbq.push_back(mk(32'hA000_1234, 32'h7777_7777, 4'b1000));
    begin
      int n = 0;
      while (!(pend && acc) && n < 20) begin
        step();
        n++;
      end
      if (!(pend && acc)) chk("rst_wait_timeout", 32'd1, 32'd0);
    end
    #2;
    rst_ = 1'b0;
    #1;
    chk_reset("midrst");
    bus.dc_wr_done = 1'b1;
    sbq.delete();
    pend = 1'b0; acc = 1'b0; m_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    spur_pct = 100;
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_cnt", bus.drained_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
